// File: rtl/piso_serializer_if.sv
// Bundle of parallel-load and serial-output handshake signals for piso_serializer.
// Both sides use valid/ready: a transfer happens on a rising edge where valid && ready are both high.
interface piso_serializer_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] i;
    logic             in_valid;
    logic             in_ready;
    logic             so;
    logic             so_valid;
    logic             so_ready;
    logic             so_first;
    logic             so_last;
    logic             busy;

    modport master (
        output i, in_valid, so_ready,
        input  in_ready, so, so_valid, so_first, so_last, busy
    );

    modport slave (
        input  i, in_valid, so_ready,
        output in_ready, so, so_valid, so_first, so_last, busy
    );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage with first/last framing and zero-bubble frame chaining.
// Optional trailing even-parity bit per frame when PISO_PARITY_EN is defined.
module piso_serializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    piso_serializer_if.slave   bus,
    output logic               dbg_state
);
`ifdef PISO_PARITY_EN
    localparam int FRAME_BITS = WIDTH + 1;
`else
    localparam int FRAME_BITS = WIDTH;
`endif
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_BITS - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d, shreg_shifted;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             active, last_bit, xfer, load, in_ready_int, data_bit;
`ifdef PISO_PARITY_EN
    logic             par_q, par_d;
`endif

    assign active   = (state_q == SHIFT);
    assign last_bit = active && (cnt_q == LAST_CNT);
    assign xfer     = active && bus.so_ready;
    // in_ready reopens on the final-bit transfer so the next frame follows with no gap.
    assign in_ready_int = (state_q == IDLE) || (xfer && last_bit);
    assign load         = bus.in_valid && in_ready_int;

    assign shreg_shifted = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                                     : {1'b0, shreg_q[WIDTH-1:1]};

`ifdef PISO_PARITY_EN
    assign data_bit = (cnt_q == CW'(WIDTH)) ? par_q
                    : (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0]);
`else
    assign data_bit = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
`endif

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
`ifdef PISO_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (load) begin
                    state_d = SHIFT;
                    shreg_d = bus.i;
                    cnt_d   = '0;
`ifdef PISO_PARITY_EN
                    par_d   = ^bus.i;
`endif
                end
            end
            SHIFT: begin
                if (xfer) begin
                    shreg_d = shreg_shifted;
                    cnt_d   = cnt_q + CW'(1);
                    if (last_bit) begin
                        cnt_d = '0;
                        if (load) begin
                            shreg_d = bus.i;
`ifdef PISO_PARITY_EN
                            par_d   = ^bus.i;
`endif
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
`ifdef PISO_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
`ifdef PISO_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign bus.in_ready = in_ready_int;
    assign bus.so_valid = active;
    assign bus.busy     = active;
    assign bus.so       = active && data_bit;
    assign bus.so_first = active && (cnt_q == '0);
    assign bus.so_last  = last_bit;
    assign dbg_state    = active;
endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: directed frames plus randomized streaming against a frame-level model.
`timescale 1ns/1ps
module tb_piso_serializer;
    localparam int WIDTH = 4;
`ifdef PISO_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FL = WIDTH + PAR;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic dbg_m, dbg_l;

    piso_serializer_if #(.WIDTH(WIDTH)) bus_m ();
    piso_serializer_if #(.WIDTH(WIDTH)) bus_l ();

    piso_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst), .bus(bus_m), .dbg_state(dbg_m)
    );
    piso_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .bus(bus_l), .dbg_state(dbg_l)
    );

    always #5 clk = ~clk;

    int n_checks;
    int n_pass;
    bit sel_lsb;

    // Reference: bits of every accepted frame queued in send order, plus position within the frame.
    logic [0:0] exp_q[$];
    bit         m_active;
    int         m_pos;

    function automatic void model_reset();
        exp_q.delete();
        m_active = 1'b0;
        m_pos    = 0;
    endfunction

    // Expected {in_ready, so_valid, busy, dbg_state, so, so_first, so_last}
    function automatic logic [6:0] model_outs(input logic sr);
        logic lst;
        logic b;
        lst = m_active && (m_pos == FL - 1);
        b   = (m_active && exp_q.size() > 0) ? exp_q[0][0] : 1'b0;
        return {(!m_active) || (sr && lst), m_active, m_active, m_active,
                b, m_active && (m_pos == 0), lst};
    endfunction

    function automatic bit model_step(input logic iv, input logic [WIDTH-1:0] w, input logic sr);
        logic lst;
        bit   ld;
        lst = m_active && (m_pos == FL - 1);
        ld  = iv && ((!m_active) || (sr && lst));
        if (m_active && sr) begin
            void'(exp_q.pop_front());
            if (lst) begin
                m_active = 1'b0;
                m_pos    = 0;
            end else begin
                m_pos++;
            end
        end
        if (ld) begin
            m_active = 1'b1;
            m_pos    = 0;
            for (int n = 0; n < WIDTH; n++)
                exp_q.push_back(sel_lsb ? w[n] : w[WIDTH-1-n]);
            if (PAR == 1) exp_q.push_back(^w);
        end
        return ld;
    endfunction

    task automatic drive(input logic iv, input logic [WIDTH-1:0] w, input logic sr);
        if (sel_lsb) begin
            bus_l.in_valid = iv; bus_l.i = w; bus_l.so_ready = sr;
            bus_m.in_valid = 1'b0; bus_m.so_ready = 1'b1;
        end else begin
            bus_m.in_valid = iv; bus_m.i = w; bus_m.so_ready = sr;
            bus_l.in_valid = 1'b0; bus_l.so_ready = 1'b1;
        end
    endtask

    function automatic logic [6:0] dut_outs();
        if (sel_lsb)
            return {bus_l.in_ready, bus_l.so_valid, bus_l.busy, dbg_l,
                    bus_l.so, bus_l.so_first, bus_l.so_last};
        return {bus_m.in_ready, bus_m.so_valid, bus_m.busy, dbg_m,
                bus_m.so, bus_m.so_first, bus_m.so_last};
    endfunction

    task automatic test_reset();
        logic [6:0] act;
        bus_m.in_valid = 1'b1; bus_m.i = 4'hF;
        bus_l.in_valid = 1'b1; bus_l.i = 4'hF;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            act = dut_outs();
            n_checks++;
            if (act !== 7'b1000000) $display("FAIL reset cyc=%0d got=%b exp=%b", c, act, 7'b1000000);
            else n_pass++;
        end
        bus_m.in_valid = 1'b0; bus_l.in_valid = 1'b0;
        rst = 1'b1;
        model_reset();
        @(posedge clk); #1;
        act = dut_outs();
        n_checks++;
        if (act !== 7'b1000000) $display("FAIL reset_release got=%b exp=%b", act, 7'b1000000);
        else n_pass++;
    endtask

    task automatic test_basic();
        logic [6:0] exp, act;
        logic [3:0] coll;
        int nb;
        coll = '0; nb = 0;
        for (int c = 0; c < FL + 2; c++) begin
            drive(c == 0, 4'b1011, 1'b1);
            @(negedge clk);
            exp = model_outs(1'b1); act = dut_outs();
            n_checks++;
            if (act !== exp) $display("FAIL basic cyc=%0d got=%b exp=%b", c, act, exp);
            else n_pass++;
            if (act[5] && nb < 4) begin coll = {coll[2:0], act[2]}; nb++; end
            void'(model_step(c == 0, 4'b1011, 1'b1));
            @(posedge clk); #1;
        end
        n_checks++;
        if (coll !== 4'b1011 || nb != 4) $display("FAIL basic_seq got=%b exp=%b", coll, 4'b1011);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [6:0] exp, act;
        logic [WIDTH-1:0] words[2];
        logic [WIDTH-1:0] w;
        logic [9:0] coll, want;
        logic iv;
        int idx, nb;
        words[0] = 4'hA; words[1] = 4'h5;
        idx = 0; nb = 0; coll = '0;
`ifdef PISO_PARITY_EN
        want = 10'b1010001010;
`else
        want = 10'b0010100101;
`endif
        for (int c = 0; c < 2 * FL + 2; c++) begin
            iv = (idx < 2);
            w  = iv ? words[idx] : '0;
            drive(iv, w, 1'b1);
            @(negedge clk);
            exp = model_outs(1'b1); act = dut_outs();
            n_checks++;
            if (act !== exp) $display("FAIL b2b cyc=%0d got=%b exp=%b", c, act, exp);
            else n_pass++;
            if (act[5]) begin coll = {coll[8:0], act[2]}; nb++; end
            if (model_step(iv, w, 1'b1)) idx++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (coll !== want || nb != 2 * FL) $display("FAIL b2b_seq got=%b n=%0d exp=%b", coll, nb, want);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [6:0] exp, act;
        logic [3:0] coll;
        logic sr;
        int nb;
        coll = '0; nb = 0;
        for (int c = 0; c < FL + 5; c++) begin
            sr = !(c >= 2 && c <= 4);
            drive(c == 0, 4'b1100, sr);
            @(negedge clk);
            exp = model_outs(sr); act = dut_outs();
            n_checks++;
            if (act !== exp) $display("FAIL backpressure cyc=%0d got=%b exp=%b", c, act, exp);
            else n_pass++;
            if (act[5] && sr && nb < 4) begin coll = {coll[2:0], act[2]}; nb++; end
            void'(model_step(c == 0, 4'b1100, sr));
            @(posedge clk); #1;
        end
        n_checks++;
        if (coll !== 4'b1100 || nb != 4) $display("FAIL backpressure_seq got=%b exp=%b", coll, 4'b1100);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [6:0] exp, act;
        logic [3:0] coll;
        int nb;
        for (int c = 0; c < 3; c++) begin
            drive(c == 0, 4'b1111, 1'b1);
            @(negedge clk);
            exp = model_outs(1'b1); act = dut_outs();
            n_checks++;
            if (act !== exp) $display("FAIL reset_mid_pre cyc=%0d got=%b exp=%b", c, act, exp);
            else n_pass++;
            void'(model_step(c == 0, 4'b1111, 1'b1));
            @(posedge clk); #1;
        end
        rst = 1'b0;
        #1;
        act = dut_outs();
        n_checks++;
        if (act !== 7'b1000000) $display("FAIL reset_mid_async got=%b exp=%b", act, 7'b1000000);
        else n_pass++;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        coll = '0; nb = 0;
        for (int c = 0; c < FL + 2; c++) begin
            drive(c == 0, 4'b0110, 1'b1);
            @(negedge clk);
            exp = model_outs(1'b1); act = dut_outs();
            n_checks++;
            if (act !== exp) $display("FAIL reset_mid_post cyc=%0d got=%b exp=%b", c, act, exp);
            else n_pass++;
            if (act[5] && nb < 4) begin coll = {coll[2:0], act[2]}; nb++; end
            void'(model_step(c == 0, 4'b0110, 1'b1));
            @(posedge clk); #1;
        end
        n_checks++;
        if (coll !== 4'b0110 || nb != 4) $display("FAIL reset_mid_seq got=%b exp=%b", coll, 4'b0110);
        else n_pass++;
    endtask

    task automatic test_bit_order();
        logic [6:0] exp, act;
        logic [3:0] coll;
        int nb;
        sel_lsb = 1'b1;
        coll = '0; nb = 0;
        for (int c = 0; c < FL + 2; c++) begin
            drive(c == 0, 4'b0001, 1'b1);
            @(negedge clk);
            exp = model_outs(1'b1); act = dut_outs();
            n_checks++;
            if (act !== exp) $display("FAIL bit_order cyc=%0d got=%b exp=%b", c, act, exp);
            else n_pass++;
            if (act[5] && nb < 4) begin coll = {coll[2:0], act[2]}; nb++; end
            void'(model_step(c == 0, 4'b0001, 1'b1));
            @(posedge clk); #1;
        end
        n_checks++;
        if (coll !== 4'b1000 || nb != 4) $display("FAIL bit_order_seq got=%b exp=%b", coll, 4'b1000);
        else n_pass++;
        sel_lsb = 1'b0;
        drive(1'b0, '0, 1'b1);
    endtask

`ifdef PISO_PARITY_EN
    task automatic test_parity();
        logic [6:0] exp, act;
        logic [4:0] coll, want;
        logic [WIDTH-1:0] w;
        for (int t = 0; t < 2; t++) begin
            w    = (t == 0) ? 4'b1011 : 4'b0011;
            want = (t == 0) ? 5'b10111 : 5'b00110;
            coll = '0;
            for (int c = 0; c < FL + 2; c++) begin
                drive(c == 0, w, 1'b1);
                @(negedge clk);
                exp = model_outs(1'b1); act = dut_outs();
                n_checks++;
                if (act !== exp) $display("FAIL parity cyc=%0d got=%b exp=%b", c, act, exp);
                else n_pass++;
                if (act[5]) coll = {coll[3:0], act[2]};
                void'(model_step(c == 0, w, 1'b1));
                @(posedge clk); #1;
            end
            n_checks++;
            if (coll !== want) $display("FAIL parity_seq word=%b got=%b exp=%b", w, coll, want);
            else n_pass++;
        end
    endtask
`endif

    task automatic test_random();
        logic [6:0] exp, act;
        logic [WIDTH-1:0] w;
        logic sr;
        bit have;
        int sent, cyc;
        have = 1'b0; sent = 0; cyc = 0; w = '0;
        while ((sent < 40 || have || m_active) && cyc < 3000) begin
            if (!have && sent < 40 && $urandom_range(0, 2) != 0) begin
                w = WIDTH'($urandom_range(0, 15));
                have = 1'b1;
            end
            sr = ($urandom_range(0, 3) != 0);
            drive(have, w, sr);
            @(negedge clk);
            exp = model_outs(sr); act = dut_outs();
            n_checks++;
            if (act !== exp) $display("FAIL random cyc=%0d got=%b exp=%b", cyc, act, exp);
            else n_pass++;
            if (model_step(have, w, sr)) begin
                have = 1'b0;
                sent++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        n_checks++;
        if (cyc >= 3000 || exp_q.size() != 0)
            $display("FAIL random_drain got=cyc %0d left %0d exp=done", cyc, exp_q.size());
        else n_pass++;
        drive(1'b0, '0, 1'b1);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        sel_lsb  = 1'b0;
        model_reset();
        bus_m.i = '0; bus_m.in_valid = 1'b0; bus_m.so_ready = 1'b1;
        bus_l.i = '0; bus_l.in_valid = 1'b0; bus_l.so_ready = 1'b1;
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_bit_order();
`ifdef PISO_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in/serial-out stage that sits directly downstream of the 4-bit parallel register. It accepts a parallel word through a valid/ready handshake and shifts it out one bit per accepted cycle, marking the first and last bit of each frame. Back-to-back words stream with no idle bit between frames, and the serial side honours downstream back-pressure.

## Interface
- WIDTH, 4, data word width in bits (legal range: WIDTH >= 2).
- MSB_FIRST, 1, bit order: 1 sends i[WIDTH-1] first; 0 sends i[0] first.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-low.
- i  input  WIDTH  parallel data word.
- in_valid  input  1  i holds a word to load.
- in_ready  output  1  serializer can accept a word this cycle.
- so  output  1  serial data bit.
- so_valid  output  1  so holds a valid bit.
- so_ready  input  1  downstream accepts so this cycle.
- so_first  output  1  current bit is the first of its frame.
- so_last  output  1  current bit is the last of its frame.
- busy  output  1  a frame is in progress (equal to so_valid).

## Operation
- States: IDLE and SHIFT.
- Internal state: shift register shreg[WIDTH-1:0] and bit counter cnt, which is $clog2(WIDTH+1) bits wide.
- Load condition: a load occurs when in_valid && in_ready at a rising edge.
  - shreg <= i, cnt <= 0, state <= SHIFT.
- in_ready is combinational:
  - 1 in IDLE.
  - In SHIFT, 1 only when so_valid && so_ready && so_last (final-bit transfer). This gives zero-bubble chaining of frames.
- so = shreg[WIDTH-1] when MSB_FIRST=1, else shreg[0].
- so_valid = (state == SHIFT).
- so_first = SHIFT && cnt == 0.
- so_last = SHIFT && cnt == WIDTH-1.
- Bit transfer condition: so_valid && so_ready.
  - shreg shifts toward the output end, filling with 0.
  - cnt increments.
- On the last-bit transfer:
  - If in_valid is high, the new word loads in the same edge, state stays SHIFT, and cnt returns to 0.
  - Otherwise state <= IDLE and cnt <= 0.
- so_ready low: shreg, cnt, state and all outputs hold. in_valid is ignored unless so_last is being transferred.
- in_valid while SHIFT and not on the last-bit transfer: the word is not taken. The upstream stage holds i and in_valid until in_ready is seen.
- so, so_first and so_last are 0 whenever so_valid is 0.

## Timing
- Reset (rst low, asynchronous): state=IDLE, shreg=0, cnt=0.
  - Outputs during reset: so=0, so_valid=0, so_first=0, so_last=0, busy=0.
  - in_ready reads 1, but no load occurs while rst is low.
  - A reset mid-frame drops the frame immediately; the remaining bits are never emitted.
- Load latency: word accepted at edge k, so this bit becomes visible after edge k.
  - Bit n of the frame is visible after edge k+n when so_ready is held high.
- Throughput: one bit per cycle. A WIDTH-bit frame occupies WIDTH cycles; with parity it occupies WIDTH+1 cycles.
- in_ready has a combinational path from so_ready; there is no combinational path from in_valid to any output.

## Configuration
- Macro: PISO_PARITY_EN.
- Defined:
  - One even-parity bit, ^(loaded word), is captured at load time.
  - The parity bit is sent after the data bits. so_last marks the parity bit at cnt == WIDTH.
  - in_ready chaining keys off that parity bit.
- Undefined:
  - Frames are WIDTH bits and so_last is asserted at cnt == WIDTH-1.
  - No parity logic is present.

## Test plan
- Basic frame: WIDTH=4, MSB_FIRST=1, so_ready=1, load 4'b1011 → so=1,0,1,1 on four consecutive cycles. so_first is high on the first bit only, so_last on the fourth only, then so_valid drops to 0.
- Back-to-back frames: 4'hA then 4'h5 with in_valid held high → eight consecutive valid bits 1,0,1,0,0,1,0,1 with no gap. The second load happens on the edge where so_last is transferred.
- Back-pressure: load 4'b1100 and drop so_ready for 3 cycles while the second bit is on so → so=1 and cnt hold. Resuming so_ready completes 1,1,0,0 with no loss or duplication; in_ready stays 0 throughout.
- Reset mid-frame: load 4'b1111, assert rst low after the second bit → all outputs go to 0 immediately. After release the block sits in IDLE with in_ready=1, and a new load of 4'b0110 emits 0,1,1,0 correctly.
- Bit order: MSB_FIRST=0, load 4'b0001 → so=1,0,0,0.
- Parity (PISO_PARITY_EN defined): load 4'b1011 → so=1,0,1,1,1, with so_last on the fifth bit. Load 4'b0011 → parity bit is 0.
